pipe_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).
- Produces PC and pipe-register write enables, per-stage flushes and the PC-select for taken branches.
- Detects load-use hazards in ID, resolves branches in MEM, and freezes the pipe while data memory is busy.
- Keeps a small FSM, a memory-wait watchdog and saturating performance counters. It sits beside the forwarding unit and drives the Pipe_Reg enable/flush controls.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 28 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encodings, register-index width,
// and the load-use hazard detect function.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W  = 5;
    localparam int WAIT_W = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        REDIRECT = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    // A load in EX whose destination is a source of the instruction in ID.
    // $zero is never a real dependency.
    function automatic logic loadUse(
        input logic             memRead,
        input logic [REG_W-1:0] exRt,
        input logic [REG_W-1:0] idRs,
        input logic [REG_W-1:0] idRt,
        input logic             usesRt
    );
        return memRead && (exRt != '0) &&
               ((exRt == idRs) || (usesRt && (exRt == idRt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
// One-cycle update latency; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipe: stalls on load-use and memory busy, redirects on taken branch.
// Controls are Mealy (same cycle as the event); state, watchdog and counters update on the next edge.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs_i,
    input  logic [4:0]       ID_rt_i,
    input  logic             ID_uses_rt_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_rt_i,
    input  logic             MEM_Branch_i,
    input  logic             MEM_Zero_i,
    input  logic             dm_busy_i,
    input  logic             cnt_clr_i,
    output logic             PCWrite_o,
    output logic             PCSrc_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Flush_o,
    output logic             EX_MEM_Flush_o,
    output logic             Pipe_Write_o,
    output logic             MEM_WB_Flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

    state_t            state;
    state_t            nextState;
    logic              lu;
    logic              tk;
    logic              luWin;
    logic              tkWin;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitNext;
    logic              errSet;

    assign lu = loadUse(EX_MemRead_i, EX_rt_i, ID_rs_i, ID_rt_i, ID_uses_rt_i);
    assign tk = MEM_Branch_i & MEM_Zero_i;

    // Busy defers a taken branch; a taken branch kills the load-use victim anyway.
    assign tkWin = tk & ~dm_busy_i;
    assign luWin = lu & ~tk & ~dm_busy_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // Event evaluation is the same from every state; MEM_WAIT holds only while busy stays high.
    always_comb begin
        nextState = RUN;
        if (dm_busy_i) begin
            nextState = MEM_WAIT;
        end else if (tk) begin
            nextState = REDIRECT;
        end else if (lu) begin
            nextState = LU_STALL;
        end
    end

    always_comb begin
        PCWrite_o      = 1'b1;
        PCSrc_o        = 1'b0;
        IF_ID_Write_o  = 1'b1;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Flush_o  = 1'b0;
        EX_MEM_Flush_o = 1'b0;
        Pipe_Write_o   = 1'b1;
        MEM_WB_Flush_o = 1'b0;
        if (!rst_n) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            Pipe_Write_o   = 1'b0;
            IF_ID_Flush_o  = 1'b1;
            ID_EX_Flush_o  = 1'b1;
            EX_MEM_Flush_o = 1'b1;
            MEM_WB_Flush_o = 1'b1;
        end else if (dm_busy_i) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            Pipe_Write_o   = 1'b0;
            MEM_WB_Flush_o = 1'b1;
        end else if (tk) begin
            PCSrc_o        = 1'b1;
            IF_ID_Flush_o  = 1'b1;
            ID_EX_Flush_o  = 1'b1;
            EX_MEM_Flush_o = 1'b1;
        end else if (lu) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Flush_o  = 1'b1;
        end
    end

    // Watchdog: counts consecutive cycles headed into MEM_WAIT.
    always_comb begin
        waitNext = '0;
        if (nextState == MEM_WAIT) begin
            waitNext = (waitCnt == '1) ? waitCnt : waitCnt + WAIT_W'(1);
        end
    end

    assign errSet = dm_busy_i && (waitNext >= MAX_WAIT_V);

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            waitCnt <= '0;
            err_o   <= 1'b0;
        end else begin
            waitCnt <= waitNext;
            if (errSet) begin
                err_o <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stallCnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc   (luWin | dm_busy_i),
        .clr   (cnt_clr_i),
        .cnt   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flushCnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc   (tkWin),
        .clr   (cnt_clr_i),
        .cnt   (flush_cnt_o)
    );

    assign state_o = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for the event/priority decode,
// plus hand sequences for memory wait, watchdog, counter saturation and reset.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;

    // Control bundle order: PCWrite, PCSrc, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Pipe_Write, MEM_WB_Flush
    localparam logic [7:0] O_NONE = 8'hA2;
    localparam logic [7:0] O_LU   = 8'h0A;
    localparam logic [7:0] O_TK   = 8'hFE;
    localparam logic [7:0] O_BUSY = 8'h01;
    localparam logic [7:0] O_RST  = 8'h1D;

    logic             clk_i = 1'b0;
    logic             rst_n;
    logic [4:0]       ID_rs_i, ID_rt_i, EX_rt_i;
    logic             ID_uses_rt_i, EX_MemRead_i, MEM_Branch_i, MEM_Zero_i, dm_busy_i, cnt_clr_i;
    logic             PCWrite_o, PCSrc_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Flush_o;
    logic             EX_MEM_Flush_o, Pipe_Write_o, MEM_WB_Flush_o, err_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
    logic [7:0]       outVec;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(8)) dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .ID_rs_i        (ID_rs_i),
        .ID_rt_i        (ID_rt_i),
        .ID_uses_rt_i   (ID_uses_rt_i),
        .EX_MemRead_i   (EX_MemRead_i),
        .EX_rt_i        (EX_rt_i),
        .MEM_Branch_i   (MEM_Branch_i),
        .MEM_Zero_i     (MEM_Zero_i),
        .dm_busy_i      (dm_busy_i),
        .cnt_clr_i      (cnt_clr_i),
        .PCWrite_o      (PCWrite_o),
        .PCSrc_o        (PCSrc_o),
        .IF_ID_Write_o  (IF_ID_Write_o),
        .IF_ID_Flush_o  (IF_ID_Flush_o),
        .ID_EX_Flush_o  (ID_EX_Flush_o),
        .EX_MEM_Flush_o (EX_MEM_Flush_o),
        .Pipe_Write_o   (Pipe_Write_o),
        .MEM_WB_Flush_o (MEM_WB_Flush_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .err_o          (err_o)
    );

    assign outVec = {PCWrite_o, PCSrc_o, IF_ID_Write_o, IF_ID_Flush_o,
                     ID_EX_Flush_o, EX_MEM_Flush_o, Pipe_Write_o, MEM_WB_Flush_o};

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRt;
        logic       memRead;
        logic [4:0] exRt;
        logic       br;
        logic       zero;
        logic       busy;
        logic [7:0] expOut;
        logic [1:0] expState;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input int rs, input int rt, input bit usesRt, input bit memRead,
                                input int exRt, input bit br, input bit zero, input bit busy,
                                input logic [7:0] expOut, input int expState);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.usesRt = usesRt; v.memRead = memRead;
        v.exRt = 5'(exRt); v.br = br; v.zero = zero; v.busy = busy;
        v.expOut = expOut; v.expState = 2'(expState);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ID_rs_i      = v.rs;
        ID_rt_i      = v.rt;
        ID_uses_rt_i = v.usesRt;
        EX_MemRead_i = v.memRead;
        EX_rt_i      = v.exRt;
        MEM_Branch_i = v.br;
        MEM_Zero_i   = v.zero;
        dm_busy_i    = v.busy;
    endtask

    initial begin
        int expStall;
        int expFlush;
        vec_t idle, luV, tkV, busyTk, busyOnly;

        idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, O_NONE, 0);
        luV      = mk(2, 0, 0, 1, 2, 0, 0, 0, O_LU, 1);
        tkV      = mk(0, 0, 0, 0, 0, 1, 1, 0, O_TK, 2);
        busyTk   = mk(0, 0, 0, 0, 0, 1, 1, 1, O_BUSY, 3);
        busyOnly = mk(0, 0, 0, 0, 0, 0, 0, 1, O_BUSY, 3);

        //              rs  rt  use mr exRt br z busy  out     state
        vecs[0]  = mk( 2,  5, 0, 1,  2, 0, 0, 0, O_LU,   1);
        vecs[1]  = mk( 0,  0, 1, 1,  0, 0, 0, 0, O_NONE, 0);
        vecs[2]  = mk( 3,  4, 1, 1,  4, 0, 0, 0, O_LU,   1);
        vecs[3]  = mk( 3,  4, 0, 1,  4, 0, 0, 0, O_NONE, 0);
        vecs[4]  = mk( 2,  2, 1, 0,  2, 0, 0, 0, O_NONE, 0);
        vecs[5]  = mk( 7,  0, 0, 1,  7, 1, 1, 0, O_TK,   2);
        vecs[6]  = mk( 1,  1, 1, 0,  9, 1, 0, 0, O_NONE, 0);
        vecs[7]  = mk( 9,  6, 1, 1,  6, 0, 1, 0, O_LU,   1);
        vecs[8]  = mk( 7,  0, 0, 1,  7, 1, 1, 1, O_BUSY, 3);
        vecs[9]  = mk( 0,  0, 0, 0,  0, 0, 0, 0, O_NONE, 0);
        vecs[10] = mk(31,  0, 0, 1, 31, 0, 0, 0, O_LU,   1);

        cnt_clr_i = 1'b0;
        drive(idle);

        // Reset state and reset-time controls
        rst_n = 1'b0;
        @(negedge clk_i); #2;
        chk("reset_ctrl", 32'(outVec), 32'(O_RST));
        @(posedge clk_i); #1;
        chk("reset_state", 32'(state_o), 0);
        chk("reset_stall", 32'(stall_cnt_o), 0);
        chk("reset_flush", 32'(flush_cnt_o), 0);
        chk("reset_err", 32'(err_o), 0);
        @(negedge clk_i);
        rst_n = 1'b1;

        // Vector table: decode and priority
        expStall = 0;
        expFlush = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk_i);
            drive(vecs[i]);
            #2;
            chk($sformatf("vec%0d_ctrl", i), 32'(outVec), 32'(vecs[i].expOut));
            @(posedge clk_i); #1;
            chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].expState));
            if (vecs[i].expOut == O_LU || vecs[i].expOut == O_BUSY) expStall++;
            if (vecs[i].expOut == O_TK) expFlush++;
        end
        chk("table_stall_cnt", 32'(stall_cnt_o), 32'(expStall));
        chk("table_flush_cnt", 32'(flush_cnt_o), 32'(expFlush));

        // Counter clear
        @(negedge clk_i);
        drive(idle);
        cnt_clr_i = 1'b1;
        @(posedge clk_i); #1;
        chk("clr_stall", 32'(stall_cnt_o), 0);
        chk("clr_flush", 32'(flush_cnt_o), 0);
        @(negedge clk_i);
        cnt_clr_i = 1'b0;

        // Busy for 3 cycles defers a pending taken branch
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_i);
            drive(busyTk);
            #2;
            chk($sformatf("busy_tk%0d_ctrl", i), 32'(outVec), 32'(O_BUSY));
            @(posedge clk_i); #1;
            chk($sformatf("busy_tk%0d_state", i), 32'(state_o), 3);
        end
        @(negedge clk_i);
        drive(tkV);
        #2;
        chk("deferred_tk_ctrl", 32'(outVec), 32'(O_TK));
        @(posedge clk_i); #1;
        chk("deferred_tk_state", 32'(state_o), 2);
        chk("deferred_stall_cnt", 32'(stall_cnt_o), 3);
        chk("deferred_flush_cnt", 32'(flush_cnt_o), 1);
        chk("deferred_err", 32'(err_o), 0);

        // Watchdog: 10 busy cycles, err visible from the 8th MEM_WAIT cycle onward
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            drive(busyOnly);
            #2;
            chk($sformatf("wd_cycle%0d_err", i), 32'(err_o), (i >= 9) ? 1 : 0);
            @(posedge clk_i); #1;
            chk($sformatf("wd_cycle%0d_state", i), 32'(state_o), 3);
        end
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk_i);
            drive(idle);
            @(posedge clk_i); #1;
            chk($sformatf("wd_after%0d_err", i), 32'(err_o), 1);
            chk($sformatf("wd_after%0d_state", i), 32'(state_o), 0);
        end

        // Saturation with 4-bit counters, then clear against a same-cycle lu
        @(negedge clk_i);
        cnt_clr_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        cnt_clr_i = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            drive(luV);
            @(posedge clk_i); #1;
            chk($sformatf("sat%0d_stall", i), 32'(stall_cnt_o), (i < 15) ? i : 15);
        end
        @(negedge clk_i);
        drive(luV);
        cnt_clr_i = 1'b1;
        @(posedge clk_i); #1;
        chk("clr_vs_lu_stall", 32'(stall_cnt_o), 0);
        @(negedge clk_i);
        cnt_clr_i = 1'b0;

        // Reset asserted in the middle of a memory wait
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk_i);
            drive(busyTk);
            @(posedge clk_i); #1;
        end
        chk("pre_rst_state", 32'(state_o), 3);
        @(negedge clk_i);
        rst_n = 1'b0;
        #2;
        chk("rst_midwait_ctrl1", 32'(outVec), 32'(O_RST));
        @(negedge clk_i); #2;
        chk("rst_midwait_ctrl2", 32'(outVec), 32'(O_RST));
        chk("rst_midwait_state", 32'(state_o), 0);
        @(negedge clk_i);
        rst_n = 1'b1;
        drive(idle);
        #2;
        chk("post_rst_state", 32'(state_o), 0);
        chk("post_rst_stall", 32'(stall_cnt_o), 0);
        chk("post_rst_flush", 32'(flush_cnt_o), 0);
        chk("post_rst_err", 32'(err_o), 0);
        chk("post_rst_ctrl", 32'(outVec), 32'(O_NONE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
